// File: rtl/alu_pkg.sv
// Shared constants for the byte-serial ALU front end: op selects, command
// byte field positions and the sequencer state encoding.
package alu_pkg;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NOTB = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_OR   = 2'b11;

  // Command byte: [1:0] op select, [2] take A from the last result
  localparam int CMD_SEL_LSB   = 0;
  localparam int CMD_SEL_MSB   = 1;
  localparam int CMD_CHAIN_BIT = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    EXEC  = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Clocked wrapper around the external combinational ALU: gathers command and
// operand bytes, samples the ALU in EXEC, and holds the result on a valid/ready port.
// Optional: ALU_SEQ_OVFCNT_EN adds a saturating overflow counter output.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             res_zero,
  output logic             res_neg
`ifdef ALU_SEQ_OVFCNT_EN
  ,
  output logic [7:0]       ovf_count
`endif
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic             take;

  assign take     = in_valid && in_ready;
  assign res_zero = (res_data == '0);
  assign res_neg  = res_data[WIDTH-1];

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (take) state_nxt = in_data[CMD_CHAIN_BIT] ? GET_B : GET_A;
      end
      GET_A: begin
        in_ready = 1'b1;
        if (take) state_nxt = GET_B;
      end
      GET_B: begin
        in_ready = 1'b1;
        if (take) state_nxt = EXEC;
      end
      EXEC:    state_nxt = HOLD;
      HOLD:    if (res_valid && res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      acc       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (take) begin
          alu_sel <= in_data[CMD_SEL_LSB +: SEL_W];
          if (in_data[CMD_CHAIN_BIT]) alu_a <= acc;
        end
        GET_A: if (take) alu_a <= in_data;
        GET_B: if (take) alu_b <= in_data;
        // ALU inputs have been stable for a full cycle; sample the result here only
        EXEC: begin
          res_data  <= alu_f;
          res_ovf   <= alu_ovf;
          acc       <= alu_f;
          res_valid <= 1'b1;
        end
        HOLD: if (res_valid && res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_OVFCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_count <= '0;
    else if (state == EXEC && alu_ovf && ovf_count != 8'hFF)
      ovf_count <= ovf_count + 8'd1;
  end
`endif

endmodule
